// File: rtl/uart_link_pkg.sv
// Shared definitions for both ends of the two-board UART number link.
// SEND_NUMS_PARITY_EN selects 8E1 frames; the receiver must use the same setting.
`timescale 1ns/1ps
package uart_link_pkg;

  localparam int   FRAME_DATA_BITS = 8;
  localparam int   NUM_BYTES       = 4;
  localparam logic START_BIT       = 1'b0;
  localparam logic STOP_BIT        = 1'b1;
  localparam logic IDLE_LEVEL      = 1'b1;

  // ST_NEXT names the byte-sequencing step; it is folded into the last STOP cycle.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_NEXT
  } link_state_e;

  function automatic logic even_parity(input logic [FRAME_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Valid/ready UART byte serializer; ready rises in the final stop-bit cycle so bytes chain.
// With SEND_NUMS_PARITY_EN an even-parity bit sits between d7 and stop.
`timescale 1ns/1ps
module uart_tx_byte
  import uart_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid,
  input  logic [FRAME_DATA_BITS-1:0] data,
  output logic                       ready,
  output logic                       serial
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(FRAME_DATA_BITS - 1);

  link_state_e                state, state_d;
  logic [CNT_W-1:0]           cnt, cnt_d;
  logic [2:0]                 idx, idx_d;
  logic [FRAME_DATA_BITS-1:0] shreg, shreg_d;
  logic                       serial_d;
  logic                       bit_end;
`ifdef SEND_NUMS_PARITY_EN
  logic                       par, par_d;
`endif

  assign bit_end = (cnt == '0);
  assign ready   = (state == ST_IDLE) || (state == ST_STOP && bit_end);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d  = state;
    cnt_d    = cnt;
    idx_d    = idx;
    shreg_d  = shreg;
    serial_d = serial;
`ifdef SEND_NUMS_PARITY_EN
    par_d    = par;
`endif
    if (state != ST_IDLE && !bit_end) cnt_d = cnt - 1'b1;

    if (valid && ready) begin
      state_d  = ST_START;
      shreg_d  = data;
      serial_d = START_BIT;
      cnt_d    = CNT_LAST;
`ifdef SEND_NUMS_PARITY_EN
      par_d    = even_parity(data);
`endif
    end else if (bit_end) begin
      cnt_d = CNT_LAST;
      case (state)
        ST_START: begin
          serial_d = shreg[0];
          shreg_d  = shreg >> 1;
          idx_d    = '0;
          state_d  = ST_DATA;
        end
        ST_DATA: begin
          if (idx == IDX_LAST) begin
`ifdef SEND_NUMS_PARITY_EN
            serial_d = par;
            state_d  = ST_PARITY;
`else
            serial_d = STOP_BIT;
            state_d  = ST_STOP;
`endif
          end else begin
            serial_d = shreg[0];
            shreg_d  = shreg >> 1;
            idx_d    = idx + 1'b1;
          end
        end
`ifdef SEND_NUMS_PARITY_EN
        ST_PARITY: begin
          serial_d = STOP_BIT;
          state_d  = ST_STOP;
        end
`endif
        ST_STOP: begin
          serial_d = IDLE_LEVEL;
          state_d  = ST_IDLE;
        end
        ST_IDLE: ;
        default: begin
          serial_d = IDLE_LEVEL;
          state_d  = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      idx    <= '0;
      serial <= IDLE_LEVEL;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      idx    <= idx_d;
      serial <= serial_d;
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded before being observed.
  always_ff @(posedge clk) begin
    shreg <= shreg_d;
`ifdef SEND_NUMS_PARITY_EN
    par   <= par_d;
`endif
  end

endmodule

// File: rtl/send_nums.sv
// Sending side of the UART number link: on a button rising edge, sends A hi, A lo, B hi, B lo.
// Define SEND_NUMS_PARITY_EN for 11-bit even-parity frames; CLK_HZ/BAUD must be at least 2.
`timescale 1ns/1ps
module send_nums
  import uart_link_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 9600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] numA,
  input  logic [15:0] numB,
  input  logic        sendBut,
  output logic        serial,
  output logic        busy,
  output logic        done
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int IDX_W        = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);

  logic             btn_q;
  logic             accept;
  logic             last_byte;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       tx_data;
  logic [IDX_W-1:0] byte_idx;
  logic [31:0]      shift_buf;

  assign accept    = sendBut && !btn_q && !busy;
  assign last_byte = (byte_idx == IDX_LAST);
  assign tx_valid  = accept || (busy && !last_byte);
  assign tx_data   = busy ? shift_buf[31:24] : numA[15:8];

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk   (clk),
    .rst   (rst),
    .valid (tx_valid),
    .data  (tx_data),
    .ready (tx_ready),
    .serial(serial)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      byte_idx <= '0;
    end else begin
      btn_q <= sendBut;
      done  <= 1'b0;
      if (accept) begin
        busy     <= 1'b1;
        byte_idx <= '0;
      end else if (busy && tx_ready) begin
        if (last_byte) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end

  // Byte 0 goes straight from numA, so the buffer is loaded pre-rotated to present A lo next.
  always_ff @(posedge clk) begin
    if (accept)
      shift_buf <= {numA[7:0], numB, numA[15:8]};
    else if (busy && tx_ready && !last_byte)
      shift_buf <= {shift_buf[23:0], shift_buf[31:24]};
  end

endmodule

// File: tb/tb_send_nums.sv
// Self-checking bench for send_nums: a mid-bit UART monitor decodes the line and is
// compared with byte/parity/timing expectations computed from the operands.
`timescale 1ns/1ps
module tb_send_nums;

  localparam int CPB = 4;  // CLK_HZ=16, BAUD=4
`ifdef SEND_NUMS_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int XFER = 4 * FRAME_BITS * CPB;

  logic        clk;
  logic        rst;
  logic [15:0] numA;
  logic [15:0] numB;
  logic        sendBut;
  logic        serial;
  logic        busy;
  logic        done;

  send_nums #(.CLK_HZ(16), .BAUD(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .numA   (numA),
    .numB   (numB),
    .sendBut(sendBut),
    .serial (serial),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] rx_q[$];
  logic       par_q[$];
  int         frame_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mon_wait(input int n, output bit aborted);
    aborted = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (rst !== 1'b1) aborted = 1'b1;
    end
  endtask

  // Line monitor: detects a start bit, then samples every bit at its centre.
  initial begin : uart_monitor
    logic [7:0] b;
    logic       p;
    bit         ab, a1;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && serial === 1'b0) begin
        b = '0;
        p = 1'b0;
        mon_wait(CPB / 2, ab);
        if (!ab && serial !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
          mon_wait(CPB, a1);
          ab   |= a1;
          b[i]  = serial;
        end
`ifdef SEND_NUMS_PARITY_EN
        mon_wait(CPB, a1);
        ab |= a1;
        p   = serial;
`endif
        mon_wait(CPB, a1);
        ab |= a1;
        if (!ab) begin
          if (serial !== 1'b1) frame_err++;
          rx_q.push_back(b);
          par_q.push_back(p);
        end
      end
    end
  end

  task automatic press();
    @(posedge clk); #1 sendBut = 1'b1;
    @(posedge clk); #1 sendBut = 1'b0;
  endtask

  task automatic compare_bytes(input string tag, input logic [7:0] exp_q[$]);
    check($sformatf("%s.nbytes", tag), rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check($sformatf("%s.byte%0d", tag, i), rx_q[i], exp_q[i]);
`ifdef SEND_NUMS_PARITY_EN
      check($sformatf("%s.par%0d", tag, i), par_q[i], $countones(exp_q[i]) % 2);
`endif
    end
    check($sformatf("%s.frame_err", tag), frame_err, 0);
  endtask

  // mode 0: plain, 1: second press at cycle 50, 2: numA change at cycle 10,
  // 3: new press in the cycle done pulses (two back-to-back transfers).
  task automatic run_xfer(input logic [15:0] a, input logic [15:0] b, input int mode,
                          input string tag);
    int n_xfer;
    int window;
    int busy_n, done_n, done_at, lows, busy_re;
    logic [7:0] exp_q[$];
    n_xfer  = (mode == 3) ? 2 : 1;
    window  = n_xfer * XFER + 30;
    busy_n  = 0; done_n = 0; done_at = 0; lows = 0; busy_re = 0;
    numA    = a;
    numB    = b;
    rx_q.delete();
    par_q.delete();
    frame_err = 0;
    press();
    for (int n = 1; n <= window; n++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        done_n++;
        lows = 0;
        if (done_at == 0) done_at = n;
      end else if (serial !== 1'b1 && busy !== 1'b1) begin
        lows++;
      end
      case (mode)
        1: if (n == 50) sendBut = 1'b1; else if (n == 51) sendBut = 1'b0;
        2: if (n == 10) numA = 16'hFFFF;
        3: if (done === 1'b1 && done_n == 1) sendBut = 1'b1;
           else if (done_at != 0 && n == done_at + 1) begin
             sendBut = 1'b0;
             busy_re = int'(busy);
           end
        default: ;
      endcase
    end
    sendBut = 1'b0;
    for (int t = 0; t < n_xfer; t++) begin
      exp_q.push_back(a / 256);
      exp_q.push_back(a % 256);
      exp_q.push_back(b / 256);
      exp_q.push_back(b % 256);
    end
    check({tag, ".busy_cycles"}, busy_n, n_xfer * XFER);
    check({tag, ".done_count"}, done_n, n_xfer);
    check({tag, ".done_cycle"}, done_at, XFER + 1);
    check({tag, ".idle_after"}, lows, 0);
    check({tag, ".busy_end"}, busy, 1'b0);
    if (mode == 3) check({tag, ".restart_busy"}, busy_re, 1);
    compare_bytes(tag, exp_q);
  endtask

  initial begin : stimulus
    int done_n, busy_n;
    logic [7:0] exp_q[$];
    rst     = 1'b0;
    sendBut = 1'b0;
    numA    = '0;
    numB    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.serial", serial, 1'b1);
    check("reset.busy", busy, 1'b0);
    check("reset.done", done, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);

    run_xfer(16'h1234, 16'h00FF, 0, "basic");
    run_xfer(16'($urandom), 16'($urandom), 1, "second_press");

    // Button held high for 500 cycles: exactly one sequence.
    numA = 16'hA5A5;
    numB = 16'h5A5A;
    rx_q.delete();
    par_q.delete();
    frame_err = 0;
    done_n = 0;
    @(posedge clk); #1 sendBut = 1'b1;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (done === 1'b1) done_n++;
    end
    @(posedge clk); #1 sendBut = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) done_n++;
    end
    check("held.done_count", done_n, 1);
    check("held.serial_idle", serial, 1'b1);
    exp_q = '{8'hA5, 8'hA5, 8'h5A, 8'h5A};
    compare_bytes("held", exp_q);

    run_xfer(16'h0102, 16'($urandom), 2, "numA_change");

    // Reset during the second byte: abort, no done, then a clean restart.
    numA = 16'hBEEF;
    numB = 16'hCAFE;
    rx_q.delete();
    par_q.delete();
    frame_err = 0;
    press();
    repeat (50) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort.serial", serial, 1'b1);
    check("abort.busy", busy, 1'b0);
    check("abort.done", done, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    done_n = 0;
    busy_n = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (done === 1'b1) done_n++;
      if (busy === 1'b1) busy_n++;
    end
    check("abort.no_done", done_n, 0);
    check("abort.no_busy", busy_n, 0);
    exp_q = '{8'hBE};
    compare_bytes("abort", exp_q);
    run_xfer(16'hBEEF, 16'hCAFE, 0, "after_abort");

    run_xfer(16'h0001, 16'h0003, 0, "parity_vec");
    run_xfer(16'($urandom), 16'($urandom), 3, "done_edge");
    for (int r = 0; r < 3; r++)
      run_xfer(16'($urandom), 16'($urandom), 0, $sformatf("rand%0d", r));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
